// File: rtl/results_collector.sv
// results_collector
// Takes the solver's result stream (one T value followed by Num_X X values per
// time step) over a valid/ready handshake. Each beat is written into the shared
// results RAM in the layout that the results sender reads. After the last step,
// the block writes the T-count and X-count header words, then raises
// Sending_Enable and holds it until Done_Sending.
//
// Ports
//   CLK, RST          clock, asynchronous active-low reset
//   Start, Num_X      run start pulse and X values per step (latched on Start)
//   Result_*          result stream handshake (Valid/Ready) and payload
//   Finish            level: the solver has no more steps
//   RAM_*             registered RAM write port (one cycle after handshake)
//   Sending_Enable    request to the sender; Done_Sending ends it
//   Busy, Error       status: Busy is high outside IDLE and ERROR; Error is sticky
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for Start
// WAIT_T  | expecting the T value of the next step, or Finish
// WAIT_X  | expecting X values of the current step
// HDR_T   | writing the T count header word
// HDR_X   | writing the X count header word
// SEND    | sender owns the RAM until Done_Sending
// ERROR   | protocol error seen; waits for a new Start
module results_collector #(
    parameter int ADDRESS_WIDTH         = 13,
    parameter int DATA_WIDTH            = 64,
    parameter int COUNTER_SIZE          = 8,
    parameter int NUMBER_OF_T_ADDRESS   = 1,
    parameter int NUMBER_OF_X_ADDRESS   = 2,
    parameter int STARTING_OF_T_ADDRESS = 3,
    parameter int STARTING_OF_X_ADDRESS = 10,
    parameter int MAX_T                 = STARTING_OF_X_ADDRESS - STARTING_OF_T_ADDRESS
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Start,
    input  logic [COUNTER_SIZE-1:0]  Num_X,
    input  logic                     Result_Valid,
    input  logic                     Result_Is_T,
    input  logic [DATA_WIDTH-1:0]    Result_Data,
    output logic                     Result_Ready,
    input  logic                     Finish,
    output logic                     RAM_Write_Enable,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address,
    output logic [DATA_WIDTH-1:0]    RAM_Data,
    output logic                     Sending_Enable,
    input  logic                     Done_Sending,
    output logic                     Busy,
    output logic                     Error
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_T, S_WAIT_X, S_HDR_T, S_HDR_X, S_SEND, S_ERROR
    } state_t;

    localparam logic [COUNTER_SIZE-1:0] MAX_T_C = COUNTER_SIZE'(MAX_T);

    state_t                    state_q, state_d;
    logic [COUNTER_SIZE-1:0]   t_count_q, t_count_d;
    logic [COUNTER_SIZE-1:0]   x_count_q, x_count_d;
    logic [COUNTER_SIZE-1:0]   num_x_q, num_x_d;
    // One extra bit so that running past the top of the address space is visible.
    logic [ADDRESS_WIDTH:0]    x_ptr_q, x_ptr_d;
    logic                      ready_q, ready_d;
    logic                      we_q, we_d;
    logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      send_en_q, send_en_d;
    logic                      busy_q, busy_d;
    logic                      error_q, error_d;
    logic                      accept;

    assign accept = Result_Valid && ready_q;

    always_comb begin
        state_d   = state_q;
        t_count_d = t_count_q;
        x_count_d = x_count_q;
        num_x_d   = num_x_q;
        x_ptr_d   = x_ptr_q;
        error_d   = error_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (Start) begin
                    error_d   = 1'b0;
                    t_count_d = '0;
                    x_count_d = '0;
                    num_x_d   = Num_X;
                    x_ptr_d   = (ADDRESS_WIDTH+1)'(STARTING_OF_X_ADDRESS);
                    if (Num_X == '0) begin
                        error_d = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_WAIT_T;
                    end
                end
            end
            S_WAIT_T: begin
                // An accepted beat takes priority; Finish is looked at again later.
                if (accept) begin
                    if (Result_Is_T) begin
                        we_d      = 1'b1;
                        addr_d    = ADDRESS_WIDTH'(STARTING_OF_T_ADDRESS) + ADDRESS_WIDTH'(t_count_q);
                        data_d    = Result_Data;
                        x_count_d = '0;
                        state_d   = S_WAIT_X;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_ERROR;
                    end
                end else if (Finish) begin
                    if (t_count_q != '0) begin
                        state_d = S_HDR_T;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_ERROR;
                    end
                end
            end
            S_WAIT_X: begin
                if (Finish) begin
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end else if (accept) begin
                    if (Result_Is_T || x_ptr_q[ADDRESS_WIDTH]) begin
                        error_d = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = x_ptr_q[ADDRESS_WIDTH-1:0];
                        data_d  = Result_Data;
                        // The running pointer stands in for 10 + x + Num_X*t.
                        x_ptr_d = x_ptr_q + 1'b1;
                        if (x_count_q + COUNTER_SIZE'(1) == num_x_q) begin
                            x_count_d = '0;
                            t_count_d = t_count_q + COUNTER_SIZE'(1);
                            state_d   = S_WAIT_T;
                        end else begin
                            x_count_d = x_count_q + COUNTER_SIZE'(1);
                        end
                    end
                end
            end
            S_HDR_T: begin
                we_d    = 1'b1;
                addr_d  = ADDRESS_WIDTH'(NUMBER_OF_T_ADDRESS);
                data_d  = DATA_WIDTH'(t_count_q);
                state_d = S_HDR_X;
            end
            S_HDR_X: begin
                we_d    = 1'b1;
                addr_d  = ADDRESS_WIDTH'(NUMBER_OF_X_ADDRESS);
                data_d  = DATA_WIDTH'(num_x_q);
                state_d = S_SEND;
            end
            S_SEND: begin
                if (Done_Sending) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = ((state_d == S_WAIT_T) && (t_count_d < MAX_T_C)) || (state_d == S_WAIT_X);
        // Held back one cycle after entering SEND so the X-count header write
        // has landed in the RAM before the sender starts reading.
        send_en_d = (state_q == S_SEND) && (state_d == S_SEND);
        busy_d    = (state_d != S_IDLE) && (state_d != S_ERROR);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            t_count_q <= '0;
            x_count_q <= '0;
            num_x_q   <= '0;
            x_ptr_q   <= '0;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            send_en_q <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_count_q <= t_count_d;
            x_count_q <= x_count_d;
            num_x_q   <= num_x_d;
            x_ptr_q   <= x_ptr_d;
            ready_q   <= ready_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            send_en_q <= send_en_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
        end
    end

    assign Result_Ready     = ready_q;
    assign RAM_Write_Enable = we_q;
    assign RAM_Address      = addr_q;
    assign RAM_Data         = data_q;
    assign Sending_Enable   = send_en_q;
    assign Busy             = busy_q;
    assign Error            = error_q;

endmodule

// File: tb/tb_results_collector.sv
// Directed bench for results_collector: drives result streams, logs RAM writes
// and handshakes, and compares against hand-computed addresses and values.
module tb_results_collector;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  Num_X = '0;
    logic        Result_Valid = 1'b0;
    logic        Result_Is_T = 1'b0;
    logic [63:0] Result_Data = '0;
    logic        Result_Ready;
    logic        Finish = 1'b0;
    logic        RAM_Write_Enable;
    logic [12:0] RAM_Address;
    logic [63:0] RAM_Data;
    logic        Sending_Enable;
    logic        Done_Sending = 1'b0;
    logic        Busy;
    logic        Error;

    results_collector dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Num_X(Num_X),
        .Result_Valid(Result_Valid), .Result_Is_T(Result_Is_T),
        .Result_Data(Result_Data), .Result_Ready(Result_Ready),
        .Finish(Finish), .RAM_Write_Enable(RAM_Write_Enable),
        .RAM_Address(RAM_Address), .RAM_Data(RAM_Data),
        .Sending_Enable(Sending_Enable), .Done_Sending(Done_Sending),
        .Busy(Busy), .Error(Error)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int se_cyc  = 0;

    logic [12:0] wr_addr[$];
    logic [63:0] wr_data[$];
    int          wr_cyc[$];
    int          hs_cyc[$];
    logic [63:0] mem [0:31];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RST && RAM_Write_Enable) begin
            wr_addr.push_back(RAM_Address);
            wr_data.push_back(RAM_Data);
            wr_cyc.push_back(cyc);
            if (RAM_Address < 13'd32) mem[RAM_Address[4:0]] = RAM_Data;
        end
        if (RST && Result_Valid && Result_Ready) hs_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); hs_cyc.delete();
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic start_run(input logic [7:0] nx);
        Num_X = nx; Start = 1'b1;
        @(posedge CLK); #1 Start = 1'b0;
    endtask

    task automatic send_beat(input logic is_t, input logic [63:0] d);
        int n = 0;
        Result_Valid = 1'b1; Result_Is_T = is_t; Result_Data = d;
        @(negedge CLK);
        while (!Result_Ready && n < 20) begin @(negedge CLK); n++; end
        chk("beat_accepted", Result_Ready, 1);
        @(posedge CLK); #1 Result_Valid = 1'b0;
    endtask

    task automatic pulse_finish();
        Finish = 1'b1;
        @(posedge CLK); #1 Finish = 1'b0;
    endtask

    task automatic wait_se();
        int n = 0;
        @(negedge CLK);
        while (!Sending_Enable && n < 30) begin @(negedge CLK); n++; end
        chk("se_rise", Sending_Enable, 1);
        se_cyc = cyc;
        @(posedge CLK); #1;
    endtask

    task automatic pulse_done();
        Done_Sending = 1'b1;
        @(posedge CLK); #1 Done_Sending = 1'b0;
    endtask

    initial begin
        logic [12:0] ea [10];
        logic [63:0] ed [10];

        for (int i = 0; i < 32; i++) mem[i] = '0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ready", Result_Ready, 0);
        chk("rst_we", RAM_Write_Enable, 0);
        chk("rst_addr", RAM_Address, 0);
        chk("rst_se", Sending_Enable, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_error", Error, 0);
        RST = 1'b1;
        @(posedge CLK); #1;

        // Run 1: Num_X=3, two steps
        start_run(3);
        chk("busy_run", Busy, 1);
        clear_log();
        send_beat(1, 100);
        for (int i = 0; i < 3; i++) send_beat(0, 64'(200 + i));
        send_beat(1, 101);
        for (int i = 0; i < 3; i++) send_beat(0, 64'(210 + i));
        pulse_finish();
        wait_se();
        ea = '{13'd3, 13'd10, 13'd11, 13'd12, 13'd4, 13'd13, 13'd14, 13'd15, 13'd1, 13'd2};
        ed = '{64'd100, 64'd200, 64'd201, 64'd202, 64'd101, 64'd210, 64'd211, 64'd212, 64'd2, 64'd3};
        chk("r1_nwrites", wr_addr.size(), 10);
        chk("r1_nhs", hs_cyc.size(), 8);
        for (int i = 0; i < 10 && i < wr_addr.size(); i++) begin
            chk($sformatf("r1_addr%0d", i), wr_addr[i], ea[i]);
            chk($sformatf("r1_data%0d", i), wr_data[i], ed[i]);
        end
        for (int i = 0; i < 8 && i < wr_cyc.size() && i < hs_cyc.size(); i++)
            chk($sformatf("r1_latency%0d", i), wr_cyc[i] - hs_cyc[i], 1);
        if (wr_cyc.size() == 10) chk("r1_se_after_hdr", se_cyc > wr_cyc[9], 1);

        // Done_Sending five cycles into SEND
        repeat (3) @(posedge CLK);
        #1 chk("send_busy", Busy, 1);
        Done_Sending = 1'b1;
        @(negedge CLK) chk("se_before_done", Sending_Enable, 1);
        @(posedge CLK); #1 Done_Sending = 1'b0;
        chk("se_after_done", Sending_Enable, 0);
        chk("busy_after_done", Busy, 0);
        chk("r1_no_send_writes", wr_addr.size(), 10);

        // Run 2: Num_X=1, fill all seven T slots
        clear_log();
        start_run(1);
        for (int t = 0; t < 7; t++) begin
            send_beat(1, 64'(300 + t));
            send_beat(0, 64'(400 + t));
        end
        Result_Valid = 1'b1; Result_Is_T = 1'b1; Result_Data = 64'd999;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("r2_full_ready", Result_Ready, 0);
        end
        chk("r2_full_nowrite", wr_addr.size(), 14);
        @(posedge CLK); #1 Result_Valid = 1'b0;
        pulse_finish();
        wait_se();
        chk("r2_hdr_t", mem[1], 7);
        chk("r2_hdr_x", mem[2], 1);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("r2_t%0d", i), mem[3 + i], 64'(300 + i));
            chk($sformatf("r2_x%0d", i), mem[10 + i], 64'(400 + i));
        end
        chk("r2_nwrites", wr_addr.size(), 16);
        pulse_done();

        // Num_X=0 at Start
        start_run(0);
        chk("nx0_error", Error, 1);
        chk("nx0_busy", Busy, 0);

        // Sequence error: T beat while expecting X
        clear_log();
        start_run(2);
        chk("restart_clears_error", Error, 0);
        send_beat(1, 700);
        send_beat(1, 701);
        @(negedge CLK);
        chk("seq_error", Error, 1);
        chk("seq_busy", Busy, 0);
        chk("seq_ready", Result_Ready, 0);
        chk("seq_nwrites", wr_addr.size(), 1);
        @(posedge CLK); #1;
        start_run(2);
        chk("seq_restart_error", Error, 0);
        chk("seq_restart_busy", Busy, 1);

        // Finish while in WAIT_X
        clear_log();
        send_beat(1, 710);
        send_beat(0, 720);
        pulse_finish();
        repeat (5) @(negedge CLK);
        chk("finx_error", Error, 1);
        chk("finx_se", Sending_Enable, 0);
        chk("finx_nwrites", wr_addr.size(), 2);
        @(posedge CLK); #1;

        // Asynchronous reset mid-WAIT_X, then a clean run
        start_run(2);
        send_beat(1, 800);
        send_beat(0, 801);
        #2 RST = 1'b0;
        #1;
        chk("arst_ready", Result_Ready, 0);
        chk("arst_we", RAM_Write_Enable, 0);
        chk("arst_addr", RAM_Address, 0);
        chk("arst_data", RAM_Data, 0);
        chk("arst_busy", Busy, 0);
        chk("arst_error", Error, 0);
        chk("arst_se", Sending_Enable, 0);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1;
        clear_log();
        start_run(2);
        send_beat(1, 500);
        send_beat(0, 600);
        send_beat(0, 601);
        pulse_finish();
        wait_se();
        chk("post_nwrites", wr_addr.size(), 5);
        if (wr_addr.size() == 5) begin
            chk("post_a0", wr_addr[0], 3);  chk("post_d0", wr_data[0], 500);
            chk("post_a1", wr_addr[1], 10); chk("post_d1", wr_data[1], 600);
            chk("post_a2", wr_addr[2], 11); chk("post_d2", wr_data[2], 601);
            chk("post_a3", wr_addr[3], 1);  chk("post_d3", wr_data[3], 1);
            chk("post_a4", wr_addr[4], 2);  chk("post_d4", wr_data[4], 2);
        end
        pulse_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/results_collector.md
Name: results_collector

Overview:
- Upstream neighbour of the results sender. Accepts the solver's output stream (one T value followed by Num_X state values per time step) through a valid/ready handshake.
- Writes the stream into the shared results RAM in the layout the sender reads:
  - T count at address 1
  - X count at address 2
  - T values from address 3
  - X values from address 10 + x + Num_X*t
- After the last step it writes both header words, then raises Sending_Enable and holds it until the sender reports Done_Sending.

Parameters:
- ADDRESS_WIDTH, 13, RAM address width
- DATA_WIDTH, 64, RAM word and result data width
- COUNTER_SIZE, 8, width of the T/X counters and of Num_X
- NUMBER_OF_T_ADDRESS, 1, header word holding the T count
- NUMBER_OF_X_ADDRESS, 2, header word holding the X count
- STARTING_OF_T_ADDRESS, 3, first T value slot
- STARTING_OF_X_ADDRESS, 10, first X value slot
- MAX_T, 7, T slots available (STARTING_OF_X_ADDRESS - STARTING_OF_T_ADDRESS)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  asynchronous reset, active-low
- Start  in  1  one-cycle pulse that begins a run; sampled only in IDLE
- Num_X  in  COUNTER_SIZE  X values per T; latched on Start
- Result_Valid  in  1  a result beat is present
- Result_Is_T  in  1  1 = beat is a T value, 0 = beat is an X value
- Result_Data  in  DATA_WIDTH  result value
- Result_Ready  out  1  collector can accept a beat this cycle
- Finish  in  1  level input: the solver has no more steps
- RAM_Write_Enable  out  1  write strobe to the RAM write port
- RAM_Address  out  ADDRESS_WIDTH  write address
- RAM_Data  out  DATA_WIDTH  write data
- Sending_Enable  out  1  request to the results sender
- Done_Sending  in  1  sender has finished
- Busy  out  1  high in every state except IDLE and ERROR
- Error  out  1  sticky protocol error flag

Behaviour:
- Reset (RST=0, asynchronous):
  - All outputs 0.
  - State IDLE; t_count, x_count and the latched Num_X are 0.
  - RST asserted mid-run aborts immediately. No further RAM writes; any partial RAM contents are abandoned.
- Handshake:
  - A beat is accepted when Result_Valid and Result_Ready are both high at a rising edge.
  - Result_Valid, Result_Is_T and Result_Data must stay stable until accepted.
- Write latency: one cycle. The accepted beat appears on RAM_Write_Enable, RAM_Address and RAM_Data in the cycle after the handshake edge. RAM_Write_Enable is high for exactly one cycle per write.
- States:
  - IDLE:
    - Ready=0.
    - Start clears Error, t_count and x_count, and latches Num_X.
    - Num_X=0 at Start: set Error, go to ERROR. Otherwise go to WAIT_T.
  - WAIT_T:
    - Ready=1 while t_count < MAX_T.
    - A T beat is written to STARTING_OF_T_ADDRESS + t_count. Then x_count=0 and the state goes to WAIT_X.
    - An X beat is a sequence error: set Error, go to ERROR, no write.
    - Finish with no beat accepted that edge:
      - t_count>0: go to HDR_T.
      - t_count=0: set Error, go to ERROR.
    - Valid and Finish at the same edge with Ready=1: the beat wins; Finish is re-sampled later.
    - t_count=MAX_T: Ready=0 and only Finish is acted on.
  - WAIT_X:
    - Ready=1.
    - An X beat is written to x_ptr, which starts at STARTING_OF_X_ADDRESS and increments once per X write. x_ptr equals STARTING_OF_X_ADDRESS + x + Num_X*t; no multiplier.
    - x_count increments per X beat. On the Num_X-th X beat, t_count increments and the state goes to WAIT_T.
    - A T beat here is a sequence error: set Error, go to ERROR, no write.
    - Finish asserted in WAIT_X: set Error, go to ERROR.
    - If x_ptr would exceed 2^ADDRESS_WIDTH-1: set Error, go to ERROR.
  - HDR_T: Ready=0. Write t_count, zero-extended to DATA_WIDTH, to NUMBER_OF_T_ADDRESS. Go to HDR_X.
  - HDR_X: Write Num_X, zero-extended, to NUMBER_OF_X_ADDRESS. Go to SEND.
  - SEND:
    - Sending_Enable=1, no RAM writes.
    - When Done_Sending is sampled 1, Sending_Enable drops on the same edge and the state goes to IDLE.
    - The header RAM writes complete at least one cycle before Sending_Enable rises.
  - ERROR:
    - Ready=0, Sending_Enable=0, Error=1.
    - Start is accepted exactly as in IDLE and clears Error.
- Start while Busy=1 is ignored.
- Counters are COUNTER_SIZE bits wide. t_count never exceeds MAX_T. x_count wraps to 0 at Num_X.

Test Plan:
- Num_X=3, two steps (T0,X00,X01,X02,T1,X10,X11,X12), then Finish:
  - Data writes at addresses 3,10,11,12,4,13,14,15, each one cycle after its handshake.
  - Headers: 2 at address 1, 3 at address 2.
  - Sending_Enable rises after the header writes.
- Continuing the previous run, Done_Sending pulsed 5 cycles into SEND: Sending_Enable falls on that edge; Busy=0 the next cycle.
- Num_X=1, seven steps written, an eighth T presented: Ready=0, no write. Then Finish: address 1 = 7; X addresses 10..16.
- Num_X=2, T accepted, then an X beat with Result_Is_T=1: Error=1, state ERROR, no write. A later Start with Num_X=2 clears Error.
- Finish in WAIT_X after 1 of 2 X values: Error=1, no header writes, Sending_Enable stays 0.
- RST low mid-WAIT_X: all outputs 0 asynchronously. After release, a new Start run writes from address 3/10 with correct headers.
